// File: rtl/config_loader.sv
// Byte-stream configuration loader: parses sync / tile address / 32-bit LSB-first word frames and
// strobes one switch_box tile (or all, address 8'hFF). Optional XOR checksum byte: CONFIG_CHECKSUM_EN.
module config_loader #(
    parameter int         NUM_TILES = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [31:0]          config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 err_addr,
    output logic                 err_chk,
    input  logic                 clear_err
);

`ifdef CONFIG_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_CHK   = 3'd3,
        S_ISSUE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_ISSUE = 3'd4
    } state_t;
`endif

    localparam logic [8:0] NUM_TILES_9 = 9'(NUM_TILES);

    state_t      state_r;
    logic [7:0]  addr_r;
    logic [31:0] word_r;
    logic [1:0]  byte_cnt_r;
    logic        accept_s;
    logic        addr_ok_s;
    logic        frame_ok_s;

`ifdef CONFIG_CHECKSUM_EN
    logic        chk_ok_r;

    function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [31:0] w);
        return a ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction
`endif

    // One-hot strobe for a tile index; 8'hFF selects every tile.
    function automatic logic [NUM_TILES-1:0] tile_strobe(input logic [7:0] a);
        logic [NUM_TILES-1:0] en;
        for (int i = 0; i < NUM_TILES; i++) begin
            en[i] = (a == 8'hFF) || (a == i[7:0]);
        end
        return en;
    endfunction

    assign accept_s  = in_valid && in_ready;
    assign addr_ok_s = (addr_r == 8'hFF) || ({1'b0, addr_r} < NUM_TILES_9);
`ifdef CONFIG_CHECKSUM_EN
    assign frame_ok_s = addr_ok_s && chk_ok_r;
`else
    assign frame_ok_s = addr_ok_s;
    assign err_chk    = 1'b0;
`endif

    // Frame parser FSM with registered strobe, data, counter and sticky error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            in_ready    <= 1'b1;
            addr_r      <= 8'h00;
            word_r      <= 32'h0000_0000;
            byte_cnt_r  <= 2'd0;
            config_data <= 32'h0000_0000;
            config_en   <= '0;
            frame_count <= '0;
            err_addr    <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            chk_ok_r    <= 1'b1;
            err_chk     <= 1'b0;
`endif
        end else begin
            config_en <= '0;
            // A flag set later in this block overrides the clear, so a new error wins.
            if (clear_err) begin
                err_addr <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
                err_chk  <= 1'b0;
`endif
            end
            case (state_r)
                S_IDLE: begin
                    if (accept_s && (in_data == SYNC_BYTE)) begin
                        state_r <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (accept_s) begin
                        addr_r     <= in_data;
                        byte_cnt_r <= 2'd0;
                        state_r    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        word_r     <= {in_data, word_r[31:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
`ifdef CONFIG_CHECKSUM_EN
                            state_r  <= S_CHK;
`else
                            state_r  <= S_ISSUE;
                            in_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef CONFIG_CHECKSUM_EN
                S_CHK: begin
                    if (accept_s) begin
                        chk_ok_r <= (in_data == frame_chk(addr_r, word_r));
                        state_r  <= S_ISSUE;
                        in_ready <= 1'b0;
                    end
                end
`endif
                S_ISSUE: begin
                    if (frame_ok_s) begin
                        config_data <= word_r;
                        config_en   <= tile_strobe(addr_r);
                        frame_count <= frame_count + CNT_W'(1);
                    end else begin
                        if (!addr_ok_s) begin
                            err_addr <= 1'b1;
                        end
`ifdef CONFIG_CHECKSUM_EN
                        if (!chk_ok_r) begin
                            err_chk <= 1'b1;
                        end
`endif
                    end
                    state_r  <= S_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state_r  <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader; CNT_W is shrunk to 4 so the frame counter wrap is reachable.
module tb_config_loader;
    localparam int NT = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   config_data;
    logic [NT-1:0] config_en;
    logic [CW-1:0] frame_count;
    logic          err_addr;
    logic          err_chk;
    logic          clear_err;

    always #5 clk = ~clk;

    config_loader #(.NUM_TILES(NT), .SYNC_BYTE(8'hA5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .config_data(config_data), .config_en(config_en), .frame_count(frame_count),
        .err_addr(err_addr), .err_chk(err_chk), .clear_err(clear_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [NT-1:0] en;
        logic [31:0]   data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            pushed = 0;
    int            pulses = 0;
    int            dbl_en = 0;
    int            long_nr = 0;
    bit            gaps = 1'b0;
    logic [7:0]    chk_byte;

    function automatic logic [7:0] model_chk(input logic [7:0] a, input logic [31:0] w);
        return a ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    task automatic push_exp(input logic [NT-1:0] en, input logic [31:0] data);
        exp_t e;
        exp_cnt = exp_cnt + 4'd1;
        e.en = en;
        e.data = data;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Strobe scoreboard plus pulse-width and in_ready low-run watchers.
    initial begin
        exp_t e;
        bit prev_en = 1'b0;
        bit prev_nr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (config_en != '0) begin
                    pulses++;
                    if (prev_en) dbl_en++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("strobe_en", config_en, e.en);
                        check_eq("strobe_data", config_data, e.data);
                        check_eq("strobe_count", frame_count, e.cnt);
                    end else begin
                        check_eq("unexpected_strobe", config_en, 16'h0000);
                    end
                end
                prev_en = (config_en != '0);
                if (!in_ready) begin
                    if (prev_nr) long_nr++;
                    prev_nr = 1'b1;
                end else begin
                    prev_nr = 1'b0;
                end
            end else begin
                prev_en = 1'b0;
                prev_nr = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check_eq("ready_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] w, input logic [7:0] c);
        chk_byte = c;
        send_byte(8'hA5);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
`ifdef CONFIG_CHECKSUM_EN
        send_byte(chk_byte);
`endif
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]    a;
        logic [31:0]   w;
        logic [NT-1:0] en;

        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_en", config_en, 16'h0000);
        check_eq("rst_data", config_data, 32'h0);
        check_eq("rst_count", frame_count, 4'h0);
        check_eq("rst_err_addr", err_addr, 1'b0);
        check_eq("rst_err_chk", err_chk, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        // T1: reset in the middle of the data bytes abandons the frame
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h78); send_byte(8'h56);
        reset = 1'b0;
        #2;
        check_eq("t1_ready", in_ready, 1'b1);
        check_eq("t1_en", config_en, 16'h0000);
        check_eq("t1_data", config_data, 32'h0);
        check_eq("t1_count", frame_count, 4'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("t1_no_strobe", pulses, 0);

        // T2: basic frame with exact strobe latency
        push_exp(16'h0008, 32'h1234_5678);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h78);
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef CONFIG_CHECKSUM_EN
        send_byte(8'h0B);
`endif
        check_eq("t2_issue_en_low", config_en, 16'h0000);
        check_eq("t2_issue_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        check_eq("t2_en", config_en, 16'h0008);
        check_eq("t2_data", config_data, 32'h1234_5678);
        check_eq("t2_count", frame_count, 4'h1);
        @(posedge clk); #1;
        check_eq("t2_en_one_cycle", config_en, 16'h0000);
        check_eq("t2_ready_back", in_ready, 1'b1);

        // T3: garbage ahead of sync is discarded
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        push_exp(16'h0020, 32'hDEAD_BEEF);
        send_frame(8'h05, 32'hDEAD_BEEF, 8'h27);
        settle();
        check_eq("t3_pulses", pulses, 2);
        check_eq("t3_data", config_data, 32'hDEAD_BEEF);
        check_eq("t3_count", frame_count, 4'h2);

        // T4: address == NUM_TILES is dropped; clear_err held across it loses to the new error
        clear_err = 1'b1;
        send_frame(8'h10, 32'hCAFE_F00D, 8'hD9);
        @(posedge clk); #1;
        clear_err = 1'b0;
        check_eq("t4_err_wins_clear", err_addr, 1'b1);
        send_frame(8'h20, 32'hCAFE_F00D, 8'hE9);
        settle();
        check_eq("t4_err_addr", err_addr, 1'b1);
        check_eq("t4_data_kept", config_data, 32'hDEAD_BEEF);
        check_eq("t4_count_kept", frame_count, 4'h2);
        push_exp(16'h8000, 32'h0000_0002);
        send_frame(8'h0F, 32'h0000_0002, 8'h0D);
        settle();
        check_eq("t4_last_tile_count", frame_count, 4'h3);
        check_eq("t4_err_sticky", err_addr, 1'b1);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check_eq("t4_err_cleared", err_addr, 1'b0);

`ifdef CONFIG_CHECKSUM_EN
        // T5: wrong checksum drops the frame
        send_frame(8'h03, 32'h1234_5678, 8'h0C);
        settle();
        check_eq("t5_err_chk", err_chk, 1'b1);
        check_eq("t5_err_addr_clean", err_addr, 1'b0);
        check_eq("t5_count_kept", frame_count, 4'h3);
        check_eq("t5_data_kept", config_data, 32'h0000_0002);
`endif
        // Broadcast frame
        push_exp(16'hFFFF, 32'h0000_0001);
        send_frame(8'hFF, 32'h0000_0001, 8'hFE);
        settle();
        check_eq("bcast_data", config_data, 32'h0000_0001);
        check_eq("bcast_count", frame_count, 4'h4);
`ifdef CONFIG_CHECKSUM_EN
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check_eq("t5_err_chk_cleared", err_chk, 1'b0);
`else
        check_eq("chk_flag_tied", err_chk, 1'b0);
`endif

        // T6: back-to-back frames with random gaps, sync value inside data, counter wraps F -> 0
        gaps = 1'b1;
        for (int i = 0; i < 14; i++) begin
            a = (i == 7) ? 8'hFF : 8'(i % NT);
            w = {8'(i), 8'hA5, 8'(i * 3), 8'h5A ^ 8'(i)};
            en = (a == 8'hFF) ? {NT{1'b1}} : (NT'(1) << a);
            push_exp(en, w);
            send_frame(a, w, model_chk(a, w));
        end
        gaps = 1'b0;
        settle();
        check_eq("t6_wrapped_count", frame_count, 4'h2);
        check_eq("t6_pending", exp_q.size(), 0);
        check_eq("total_pulses", pulses, pushed);
        check_eq("en_multi_cycle", dbl_en, 0);
        check_eq("ready_low_run", long_nr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
